// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Combinational decode only; no state, no latency, no backpressure.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int BUB_W     = 2;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  // Control word a flushed pipeline register loads: no writeback, no memory op, no ALU effect.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, sticks at all-ones; cleared by async reset.
// Count visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-resolved branches, memory waits.
// Strobes are combinational from state+inputs; memory wait freezes every stage.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic             dmem_req,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_BUBBLES - 1);

  state_e           state_q, state_d, ret_q, ret_d, eff_st;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic             mem_op, taken, lu, wait_c;
  logic             stall_inc, flush_inc;

  assign mem_op = mem_read | mem_write;
  assign taken  = mem_branch & mem_zero;
  assign lu     = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign wait_c = mem_op & ~dmem_ready;
  // The release cycle of a wait behaves exactly like a cycle of the state it interrupted.
  assign eff_st = (state_q == WAIT) ? ret_q : state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    bub_d   = bub_q;
    if (wait_c) begin
      state_d = WAIT;
      ret_d   = eff_st;
    end else if (taken) begin
      state_d = RUN;
      bub_d   = '0;
    end else if (eff_st == STALL) begin
      if (bub_q <= BUB_W'(1)) begin
        state_d = RUN;
        bub_d   = '0;
      end else begin
        state_d = STALL;
        bub_d   = bub_q - 1'b1;
      end
    end else begin
      state_d = RUN;
      if (lu) begin
        bub_d   = BUB_INIT;
        state_d = (BUB_INIT == '0) ? RUN : STALL;
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_src      = 1'b0;
    dmem_req    = rst_n & mem_op;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (wait_c) begin
      pc_en = 1'b0;
    end else if (taken) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      pc_src = 1'b1;
    end else if ((eff_st == STALL) || ((eff_st == RUN) && lu)) begin
      {idex_en, exmem_en, memwb_en} = 3'b111;
      idex_flush = 1'b1;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
    end
  end

  assign state     = state_q;
  assign stall_inc = rst_n & ~pc_en;
  assign flush_inc = rst_n & ~wait_c & taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: three sequencer instances (1 bubble, 2 bubbles, 4-bit counters) on shared stimulus.
module tb_pipeline_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_read, mem_write, dmem_ready;

  // enable vectors are {pc, ifid, idex, exmem, memwb}; flush vectors are {ifid, idex, exmem}
  wire [4:0]  en_a, en_b, en_c;
  wire [2:0]  fl_a, fl_b, fl_c;
  wire        pcs_a, pcs_b, pcs_c, req_a, req_b, req_c;
  wire [1:0]  st_a, st_b, st_c;
  wire [15:0] sc_a, fc_a, sc_b, fc_b;
  wire [3:0]  sc_c, fc_c;

  int n_chk = 0;
  int n_err = 0;

  pipeline_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready),
    .pc_en(en_a[4]), .ifid_en(en_a[3]), .idex_en(en_a[2]), .exmem_en(en_a[1]), .memwb_en(en_a[0]),
    .ifid_flush(fl_a[2]), .idex_flush(fl_a[1]), .exmem_flush(fl_a[0]),
    .pc_src(pcs_a), .dmem_req(req_a), .state(st_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipeline_ctrl #(.LOAD_BUBBLES(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready),
    .pc_en(en_b[4]), .ifid_en(en_b[3]), .idex_en(en_b[2]), .exmem_en(en_b[1]), .memwb_en(en_b[0]),
    .ifid_flush(fl_b[2]), .idex_flush(fl_b[1]), .exmem_flush(fl_b[0]),
    .pc_src(pcs_b), .dmem_req(req_b), .state(st_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  pipeline_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready),
    .pc_en(en_c[4]), .ifid_en(en_c[3]), .idex_en(en_c[2]), .exmem_en(en_c[1]), .memwb_en(en_c[0]),
    .ifid_flush(fl_c[2]), .idex_flush(fl_c[1]), .exmem_flush(fl_c[0]),
    .pc_src(pcs_c), .dmem_req(req_c), .state(st_c), .stall_cnt(sc_c), .flush_cnt(fc_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rt_dst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt);
    idle_inputs();
    ex_mem_read = 1'b1; ex_rt = rt_dst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_read = 1'b1;
    #2;
    check_eq("rst_en",    32'(en_a),  32'h00);
    check_eq("rst_flush", 32'(fl_a),  32'h7);
    check_eq("rst_req",   32'(req_a), 32'h0);
    check_eq("rst_pcsrc", 32'(pcs_a), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_read = 1'b0;
    #1;
    check_eq("post_rst_state", 32'(st_a),  32'd0);
    check_eq("post_rst_en",    32'(en_a),  32'h1F);
    check_eq("post_rst_flush", 32'(fl_a),  32'h0);
    check_eq("post_rst_scnt",  32'(sc_a),  32'd0);
    check_eq("post_rst_fcnt",  32'(fc_a),  32'd0);

    // load-use on rs, one bubble
    set_lu(5'd8, 5'd8, 5'd0, 1'b0);
    #1;
    check_eq("lu_en",    32'(en_a), 32'h07);
    check_eq("lu_flush", 32'(fl_a), 32'h2);
    tick();
    idle_inputs();
    #1;
    check_eq("lu_done_en",    32'(en_a), 32'h1F);
    check_eq("lu_done_state", 32'(st_a), 32'd0);
    check_eq("lu_scnt",       32'(sc_a), 32'd1);
    set_lu(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check_eq("lu_r0_en", 32'(en_a), 32'h1F);
    tick();
    set_lu(5'd9, 5'd3, 5'd9, 1'b0);
    #1;
    check_eq("lu_rt_unused_en", 32'(en_a), 32'h1F);
    tick();
    set_lu(5'd9, 5'd3, 5'd9, 1'b1);
    #1;
    check_eq("lu_rt_en", 32'(en_a), 32'h07);
    tick();
    idle_inputs();
    #1;
    check_eq("lu_rt_scnt", 32'(sc_a), 32'd2);

    // taken / not-taken branch
    mem_branch = 1'b1; mem_zero = 1'b1;
    #1;
    check_eq("br_pcsrc", 32'(pcs_a), 32'h1);
    check_eq("br_flush", 32'(fl_a),  32'h7);
    check_eq("br_en",    32'(en_a),  32'h1F);
    tick();
    idle_inputs();
    #1;
    check_eq("br_fcnt", 32'(fc_a), 32'd1);
    mem_branch = 1'b1; mem_zero = 1'b0;
    #1;
    check_eq("nt_pcsrc", 32'(pcs_a), 32'h0);
    check_eq("nt_flush", 32'(fl_a),  32'h0);
    tick();
    idle_inputs();
    #1;
    check_eq("nt_fcnt", 32'(fc_a), 32'd1);

    // four-cycle memory wait
    do_reset();
    mem_read = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("mw_en",  32'(en_a),  32'h00);
      check_eq("mw_fl",  32'(fl_a),  32'h0);
      check_eq("mw_req", 32'(req_a), 32'h1);
      tick();
      check_eq("mw_state", 32'(st_a), 32'd2);
    end
    dmem_ready = 1'b1;
    #1;
    check_eq("mw_rel_en", 32'(en_a), 32'h1F);
    tick();
    idle_inputs();
    #1;
    check_eq("mw_rel_state", 32'(st_a), 32'd0);
    check_eq("mw_scnt",      32'(sc_a), 32'd4);
    mem_write = 1'b1; dmem_ready = 1'b1;
    #1;
    check_eq("zw_en",  32'(en_a),  32'h1F);
    check_eq("zw_req", 32'(req_a), 32'h1);
    tick();
    check_eq("zw_state", 32'(st_a), 32'd0);
    idle_inputs();

    // two bubbles interrupted by a memory wait, then a branch cancelling a stall
    do_reset();
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    check_eq("b_lu_en", 32'(en_b), 32'h07);
    tick();
    check_eq("b_stall_state", 32'(st_b), 32'd1);
    idle_inputs();
    mem_read = 1'b1; dmem_ready = 1'b0;
    #1;
    check_eq("b_mw_en", 32'(en_b), 32'h00);
    tick();
    check_eq("b_mw_state1", 32'(st_b), 32'd2);
    tick();
    check_eq("b_mw_state2", 32'(st_b), 32'd2);
    dmem_ready = 1'b1;
    #1;
    check_eq("b_resume_en", 32'(en_b), 32'h07);
    check_eq("b_resume_fl", 32'(fl_b), 32'h2);
    tick();
    idle_inputs();
    #1;
    check_eq("b_done_state", 32'(st_b), 32'd0);
    check_eq("b_done_en",    32'(en_b), 32'h1F);
    check_eq("b_scnt",       32'(sc_b), 32'd4);
    set_lu(5'd6, 5'd0, 5'd6, 1'b1);
    #1;
    tick();
    check_eq("b_stall2_state", 32'(st_b), 32'd1);
    idle_inputs();
    mem_branch = 1'b1; mem_zero = 1'b1;
    #1;
    check_eq("b_br_en",    32'(en_b),  32'h1F);
    check_eq("b_br_pcsrc", 32'(pcs_b), 32'h1);
    check_eq("b_br_fl",    32'(fl_b),  32'h7);
    tick();
    idle_inputs();
    #1;
    check_eq("b_br_state", 32'(st_b), 32'd0);
    check_eq("b_br_fcnt",  32'(fc_b), 32'd1);
    check_eq("b_br_run",   32'(en_b), 32'h1F);

    // saturation, then reset in the middle of a wait
    do_reset();
    mem_read = 1'b1; dmem_ready = 1'b0;
    repeat (20) tick();
    check_eq("sat_scnt_c",  32'(sc_c), 32'd15);
    check_eq("wide_scnt_a", 32'(sc_a), 32'd20);
    check_eq("sat_state_c", 32'(st_c), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(st_c),  32'd0);
    check_eq("arst_req",   32'(req_c), 32'h0);
    check_eq("arst_scnt",  32'(sc_c),  32'd0);
    check_eq("arst_en",    32'(en_c),  32'h00);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It watches the ID stage, the ID/EX load destination and the EX/MEM branch/memory controls, and drives the enable and flush strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the branch-redirect select. It resolves three hazards: load-use bubbles, taken branches resolved in MEM, and multi-cycle data-memory accesses. It also keeps saturating stall and flush performance counters.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..3).
- CNT_W, 16: width of each performance counter.
- clk in 1: pipeline clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- id_rs in 5: rs field of the instruction in ID.
- id_rt in 5: rt field of the instruction in ID.
- id_uses_rt in 1: the ID instruction reads rt.
- ex_mem_read in 1: the ID/EX instruction is a load.
- ex_rt in 5: destination register of that load.
- mem_branch in 1: EX/MEM Branch bit.
- mem_zero in 1: EX/MEM ZeroFlag.
- mem_read in 1: EX/MEM MemRead bit.
- mem_write in 1: EX/MEM MemWrite bit.
- dmem_ready in 1: data memory completes the current access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en out 1: register load enables.
- ifid_flush, idex_flush, exmem_flush out 1: load a bubble (all control bits 0) at the next edge.
- pc_src out 1: select the branch target as the next PC.
- dmem_req out 1: data-memory access request.
- state out 2: current FSM state (RUN=0, STALL=1, WAIT=2).
- stall_cnt out CNT_W: cycles with pc_en=0 since reset.
- flush_cnt out CNT_W: taken branches since reset.

## Operation
- All strobes are combinational from the registered state, the bubble counter and the inputs.
- **Hazard definitions:**
  - mem_op = mem_read|mem_write.
  - taken = mem_branch & mem_zero.
  - lu = ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- **Priority, highest first:** memory wait, taken branch, load-use, run.
- **Memory wait:**
  - dmem_req = mem_op whenever rst_n is high.
  - If mem_op & !dmem_ready, every enable is 0, nothing is flushed, and the FSM goes to WAIT (or stays there).
  - The cycle dmem_ready rises, the pipeline advances normally and the FSM returns to the state held before WAIT. That is STALL with its bubble count preserved, or RUN.
  - Zero-wait access: mem_op & dmem_ready in RUN never enters WAIT.
- **Taken branch (not blocked by a memory wait):**
  - pc_src=1, ifid_flush=idex_flush=exmem_flush=1, all enables 1.
  - flush_cnt increments.
  - Any pending load-use stall is cancelled: bubble counter cleared, FSM to RUN.
  - mem_branch together with mem_op is illegal; the WAIT priority applies.
- **Load-use (RUN only):**
  - Entry cycle: pc_en=ifid_en=0, idex_flush=1, the other enables 1.
  - The FSM enters STALL with bubble counter = LOAD_BUBBLES-1.
  - If the counter is 0, the FSM returns directly to RUN.
- **STALL:**
  - Outputs are the same as at load-use entry.
  - The counter decrements each advancing cycle; the FSM returns to RUN when it reaches 0.
  - lu is not re-evaluated inside STALL.
- **RUN with no hazard:** all enables 1, flushes 0, pc_src 0.
- **Counters:**
  - stall_cnt +1 on every cycle with rst_n high and pc_en=0.
  - flush_cnt as above.
  - Both saturate at all-ones.
- **Reset asserted (asynchronous):**
  - State RUN, bubble counter 0, both perf counters 0.
  - While rst_n is low: all enables 0, all flushes 1, pc_src 0, dmem_req 0.
  - Reset during WAIT or STALL aborts it immediately.

## Timing
- pc_src and the flush strobes are valid in the same cycle that taken is true. The wrong-path instructions are squashed at the next rising edge.
- Branch penalty is 3 cycles.
- Load-use penalty is LOAD_BUBBLES cycles. Memory wait penalty is the number of cycles with !dmem_ready.
- Counter updates are visible one cycle after the qualifying cycle.
- state reflects the registered FSM; it changes only on rising clk edges or on rst_n falling.

## Structure
- Package pipeline_pkg:
  - state enum (RUN, STALL, WAIT).
  - Default CNT_W.
  - Bubble-control constant (all-zero WB/M/EX).
- Sub-module sat_counter (parameter W; inputs inc and rst_n; saturating), instantiated twice for the perf counters.
- FSM and hazard compare in pipeline_ctrl.

## Test plan
- **Reset:** hold rst_n low for 3 cycles. Expect enables 0, flushes 1, dmem_req 0. After release: state=RUN, enables 1, counters 0.
- **Load-use:** ex_mem_read=1, ex_rt=8, id_rs=8. Expect pc_en=ifid_en=0 and idex_flush=1 for exactly 1 cycle (LOAD_BUBBLES=1), stall_cnt=1. Repeat with ex_rt=0: no stall.
- **Taken branch:** mem_branch=1, mem_zero=1. Expect pc_src=1 and three flushes in the same cycle, flush_cnt=1. With mem_zero=0: pc_src=0, no flush.
- **Memory wait:** mem_read=1, dmem_ready low for 4 cycles. Expect state=WAIT and all enables 0 for 4 cycles, stall_cnt=4. Release on cycle 5.
- **Simultaneous load-use during WAIT, LOAD_BUBBLES=2:** expect the stall to resume with its count intact after dmem_ready. Then a taken branch during STALL: expect the stall cancelled and state=RUN.
- **Saturation (CNT_W=4), reset mid-WAIT:** after 20 stalled cycles stall_cnt=15. Reset mid-WAIT gives state=RUN and dmem_req=0 immediately.
